// File: rtl/mv_pred_sequencer_pkg.sv
// mv_seq_pkg: shared definitions for the motion-vector predictor sequencer.
//   state_t             - sequencer FSM state encoding (3 bits)
//   FH, FV, BH, BV      - PMV component indices (fwd-h, fwd-v, bwd-h, bwd-v)
//   ACK_TIMEOUT_DEFAULT - default decode-ack wait limit (timeout build only)
package mv_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEL      = 3'd1,
        ST_WAIT_MC  = 3'd2,
        ST_ISSUE    = 3'd3,
        ST_WAIT_ACK = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam logic [1:0] FH = 2'd0;
    localparam logic [1:0] FV = 2'd1;
    localparam logic [1:0] BH = 2'd2;
    localparam logic [1:0] BV = 2'd3;

    localparam int unsigned ACK_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mv_pmv_regfile.sv
// mv_pmv_regfile: the four PMV predictor registers.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   clr             - zero all four registers (wins over a same-cycle write)
//   we/waddr/wdata  - single write port, waddr uses FH/FV/BH/BV indices
//   fh, fv, bh, bv  - current register values
module mv_pmv_regfile
    import mv_seq_pkg::*;
#(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         we,
    input  logic [1:0]   waddr,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] fh,
    output logic [W-1:0] fv,
    output logic [W-1:0] bh,
    output logic [W-1:0] bv
);

    logic [W-1:0] pmv [4];

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int unsigned i = 0; i < 4; i++) begin
                pmv[i] <= '0;
            end
        end else if (we) begin
            pmv[waddr] <= wdata;
        end
    end

    assign fh = pmv[FH];
    assign fv = pmv[FV];
    assign bh = pmv[BH];
    assign bv = pmv[BV];

endmodule

// File: rtl/mv_pred_sequencer.sv
// mv_pred_sequencer: per-macroblock controller between the motion_code /
// motion_residual parser and decode_motion_vector. Walks fwd-h, fwd-v,
// bwd-h, bwd-v (skipping absent directions), accepts one code/residual pair
// per component, issues a decode request with the current PMV and writes
// the returned prediction back. Values pass through unmodified.
// Ports:
//   mb_start/mb_fwd/mb_bwd/mb_intra - macroblock header (sampled on mb_start)
//   full_pel_fwd/full_pel_bwd       - forwarded as dmv_full_pel per direction
//   pmv_clear                       - slice-start PMV reset, any state
//   mc_valid/mc_ready/motion_code/motion_residual - upstream handshake
//   dmv_valid/dmv_pred/dmv_code/dmv_resid/dmv_full_pel - decode request
//   dmv_ack/dmv_result              - decoder response
//   busy, mb_done, mv_fh/fv/bh/bv   - status and current PMVs
//   err                             - sticky ack-timeout flag
// Optional feature: define MV_TIMEOUT_EN to abort a macroblock when no
// dmv_ack arrives within ACK_TIMEOUT cycles; otherwise err is tied 0.
module mv_pred_sequencer
    import mv_seq_pkg::*;
#(
    parameter int unsigned W           = 32,
    parameter int unsigned ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mb_start,
    input  logic         mb_fwd,
    input  logic         mb_bwd,
    input  logic         mb_intra,
    input  logic         full_pel_fwd,
    input  logic         full_pel_bwd,
    input  logic         pmv_clear,
    input  logic         mc_valid,
    output logic         mc_ready,
    input  logic [W-1:0] motion_code,
    input  logic [W-1:0] motion_residual,
    output logic         dmv_valid,
    output logic [W-1:0] dmv_pred,
    output logic [W-1:0] dmv_code,
    output logic [W-1:0] dmv_resid,
    output logic         dmv_full_pel,
    input  logic         dmv_ack,
    input  logic [W-1:0] dmv_result,
    output logic         busy,
    output logic         mb_done,
    output logic [W-1:0] mv_fh,
    output logic [W-1:0] mv_fv,
    output logic [W-1:0] mv_bh,
    output logic [W-1:0] mv_bv,
    output logic         err
);

    state_t       state;
    logic [2:0]   idx;        // 0..3 component, 4 = past the last one
    logic         fwd_q;
    logic         bwd_q;
    logic [W-1:0] pmv_sel;
    logic         pmv_we;
    logic         pmv_clr;

`ifdef MV_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT + 1);
    logic [CNT_W-1:0] ack_cnt;
`endif

    assign mc_ready = (state == ST_WAIT_MC);
    assign busy     = (state != ST_IDLE);
    assign pmv_we   = (state == ST_WAIT_ACK) && dmv_ack;
    assign pmv_clr  = pmv_clear || ((state == ST_IDLE) && mb_start && mb_intra);

    mv_pmv_regfile #(.W(W)) u_regfile (
        .clk   (clk),
        .rst   (rst),
        .clr   (pmv_clr),
        .we    (pmv_we),
        .waddr (idx[1:0]),
        .wdata (dmv_result),
        .fh    (mv_fh),
        .fv    (mv_fv),
        .bh    (mv_bh),
        .bv    (mv_bv)
    );

    always_comb begin
        pmv_sel = '0;
        case (idx[1:0])
            FH: pmv_sel = mv_fh;
            FV: pmv_sel = mv_fv;
            BH: pmv_sel = mv_bh;
            BV: pmv_sel = mv_bv;
            default: pmv_sel = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            idx          <= '0;
            fwd_q        <= 1'b0;
            bwd_q        <= 1'b0;
            dmv_valid    <= 1'b0;
            dmv_pred     <= '0;
            dmv_code     <= '0;
            dmv_resid    <= '0;
            dmv_full_pel <= 1'b0;
            mb_done      <= 1'b0;
`ifdef MV_TIMEOUT_EN
            ack_cnt      <= '0;
            err          <= 1'b0;
`endif
        end else begin
            dmv_valid <= 1'b0;
            mb_done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mb_start) begin
                        if (mb_intra) begin
                            state <= ST_DONE;
                        end else begin
                            fwd_q <= mb_fwd;
                            bwd_q <= mb_bwd;
                            idx   <= '0;
                            state <= ST_SEL;
                        end
                    end
                end
                ST_SEL: begin
                    // idx < 2 is a fwd slot, 2..3 a bwd slot, 4 is exhausted.
                    if (!idx[2] && !idx[1] && fwd_q) begin
                        state <= ST_WAIT_MC;
                    end else if (!idx[2] && bwd_q) begin
                        if (!idx[1]) begin
                            idx <= {1'b0, BH};
                        end
                        state <= ST_WAIT_MC;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                ST_WAIT_MC: begin
                    if (mc_valid) begin
                        dmv_code  <= motion_code;
                        dmv_resid <= motion_residual;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    dmv_valid    <= 1'b1;
                    dmv_pred     <= pmv_sel;
                    dmv_full_pel <= idx[1] ? full_pel_bwd : full_pel_fwd;
`ifdef MV_TIMEOUT_EN
                    ack_cnt      <= '0;
`endif
                    state        <= ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (dmv_ack) begin
                        idx   <= idx + 3'd1;
                        state <= ST_SEL;
                    end
`ifdef MV_TIMEOUT_EN
                    else if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        err   <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                    end
`endif
                end
                ST_DONE: begin
                    mb_done <= 1'b1;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef MV_TIMEOUT_EN
    assign err = 1'b0;
`endif

endmodule
